// File: rtl/register_loader.sv
// Write-side front end for the vector / ternary-matrix register file: assembles narrow beats into full payloads.
// Optional broadcast vector writes (index 8'hFF) are enabled by defining REGISTER_LOADER_BROADCAST_EN.
module register_loader #(
  parameter int VectorBits         = 64,
  parameter int TmBits             = 80,
  parameter int NumVectorRegisters = 4,
  parameter int BusWidth           = 32,
  parameter int VBeats             = (VectorBits + BusWidth - 1) / BusWidth,
  parameter int TmBeats            = (TmBits + BusWidth - 1) / BusWidth
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           in_valid_i,
  output logic                                           in_ready_o,
  input  logic [BusWidth-1:0]                            in_data_i,
  output logic [NumVectorRegisters-1:0]                  w_v_en_o,
  output logic [NumVectorRegisters-1:0][VectorBits-1:0]  w_v_data_o,
  output logic                                           w_tm_en_o,
  output logic [TmBits-1:0]                              w_tm_data_o,
  output logic                                           busy_o,
  output logic                                           done_o,
  output logic                                           err_o
);

  localparam int MaxBeats = (VBeats > TmBeats) ? VBeats : TmBeats;
  localparam int CntW     = $clog2(MaxBeats + 1);

`ifdef REGISTER_LOADER_BROADCAST_EN
  localparam bit BroadcastEn = 1'b1;
`else
  localparam bit BroadcastEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    COMMIT,
    ERR
  } state_t;

  state_t                        state, state_next;
  logic                          target_mtx, target_mtx_next;
  logic [7:0]                    index, index_next;
  logic [CntW-1:0]               count, count_next;
  logic                          xfer, last_beat, header_ok;
  logic                          ready_next, done_next, err_next, tm_en_next;
  logic [NumVectorRegisters-1:0] v_en_next;
  logic [VectorBits-1:0]         vec_q;

  assign xfer      = in_valid_i && in_ready_o;
  assign last_beat = int'(count) == ((target_mtx ? TmBeats : VBeats) - 1);
  assign header_ok = in_data_i[BusWidth-1]
                  || (int'(in_data_i[7:0]) < NumVectorRegisters)
                  || (BroadcastEn && (in_data_i[7:0] == 8'hFF));
  assign busy_o    = (state != IDLE);
  assign w_v_data_o = {NumVectorRegisters{vec_q}};

  // Handshake outputs and strobes are decoded from the next state so they appear registered.
  always_comb begin
    state_next      = state;
    target_mtx_next = target_mtx;
    index_next      = index;
    count_next      = count;
    case (state)
      IDLE: begin
        if (xfer) begin
          target_mtx_next = in_data_i[BusWidth-1];
          index_next      = in_data_i[7:0];
          count_next      = '0;
          state_next      = header_ok ? LOAD : DRAIN;
        end
      end
      LOAD: begin
        if (xfer) begin
          count_next = count + 1'b1;
          if (last_beat) state_next = COMMIT;
        end
      end
      DRAIN: begin
        if (xfer) begin
          count_next = count + 1'b1;
          if (last_beat) state_next = ERR;
        end
      end
      COMMIT:  state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    ready_next = (state_next == IDLE) || (state_next == LOAD) || (state_next == DRAIN);
    done_next  = (state_next == COMMIT) || (state_next == ERR);
    err_next   = (state_next == ERR);
    tm_en_next = (state_next == COMMIT) && target_mtx_next;
    v_en_next  = '0;
    if ((state_next == COMMIT) && !target_mtx_next) begin
      for (int i = 0; i < NumVectorRegisters; i++) begin
        v_en_next[i] = (index_next == 8'(i)) || (BroadcastEn && (index_next == 8'hFF));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      target_mtx <= 1'b0;
      index      <= '0;
      count      <= '0;
      in_ready_o <= 1'b0;
      w_v_en_o   <= '0;
      w_tm_en_o  <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_next;
      target_mtx <= target_mtx_next;
      index      <= index_next;
      count      <= count_next;
      in_ready_o <= ready_next;
      w_v_en_o   <= v_en_next;
      w_tm_en_o  <= tm_en_next;
      done_o     <= done_next;
      err_o      <= err_next;
    end
  end

  // Beat k lands LSB-first at bit k*BusWidth; bits past the payload width are simply never stored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vec_q       <= '0;
      w_tm_data_o <= '0;
    end else if ((state == LOAD) && xfer) begin
      for (int b = 0; b < VectorBits; b++) begin
        if (!target_mtx && (b / BusWidth == int'(count))) vec_q[b] <= in_data_i[b % BusWidth];
      end
      for (int b = 0; b < TmBits; b++) begin
        if (target_mtx && (b / BusWidth == int'(count))) w_tm_data_o[b] <= in_data_i[b % BusWidth];
      end
    end
  end

endmodule

// File: tb/tb_register_loader.sv
// Directed self-checking bench for register_loader (64-bit vectors, 80-bit matrix, 32-bit bus, 4 registers).
// Broadcast expectations follow REGISTER_LOADER_BROADCAST_EN.
module tb_register_loader;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             inValid = 1'b0;
  logic [31:0]      inData = '0;
  logic             inReady;
  logic [3:0]       wVEn;
  logic [3:0][63:0] wVData;
  logic             wTmEn;
  logic [79:0]      wTmData;
  logic             busy, done, err;

  int assertions = 0;
  int failures   = 0;
  int cycle      = 0;
  int vPulses    = 0;
  int tmPulses   = 0;
  int errPulses  = 0;
  int donePulses = 0;

  register_loader dut (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .in_data_i  (inData),
    .w_v_en_o   (wVEn),
    .w_v_data_o (wVData),
    .w_tm_en_o  (wTmEn),
    .w_tm_data_o(wTmData),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Pulse counters sampled mid-cycle; read them only in cycles where the counted signal is low.
  always @(negedge clock) begin
    if (|wVEn) vPulses++;
    if (wTmEn) tmPulses++;
    if (err)   errPulses++;
    if (done)  donePulses++;
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the transfer edge.
  task automatic applyStimulus(input logic [31:0] data, output int xferCycle);
    int waited = 0;
    inValid = 1'b1;
    inData  = data;
    while (!inReady && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("ready_wait", 256'(waited < 20), 256'(1));
    xferCycle = cycle;
    @(negedge clock);
    inValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int          xc, h0, h1, idx, cyc, readyLow;
    logic [31:0] seq [6];

    #1;
    checkOutput("reset_ready", inReady, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_en", {wVEn, wTmEn}, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_ready", inReady, 1);
    checkOutput("post_reset_busy", busy, 0);

    $display("[TB] vector load to index 2");
    applyStimulus(32'h0000_0002, xc);
    checkOutput("vload_busy", busy, 1);
    applyStimulus(32'h1111_1111, xc);
    applyStimulus(32'h2222_2222, xc);
    checkOutput("vload_en", wVEn, 4'b0100);
    checkOutput("vload_data2", wVData[2], 64'h2222_2222_1111_1111);
    checkOutput("vload_data0", wVData[0], 64'h2222_2222_1111_1111);
    checkOutput("vload_done", done, 1);
    checkOutput("vload_commit_ready", inReady, 0);
    checkOutput("vload_tm_en", wTmEn, 0);
    @(negedge clock);
    checkOutput("vload_en_after", wVEn, 0);
    checkOutput("vload_done_after", done, 0);
    checkOutput("vload_ready_after", inReady, 1);
    checkOutput("vload_busy_after", busy, 0);

    $display("[TB] matrix load with stalls");
    tmPulses = 0; vPulses = 0;
    applyStimulus(32'h8000_0000, xc);
    applyStimulus(32'hAAAA_AAAA, xc);
    repeat (2) @(negedge clock);
    checkOutput("mload_stall_ready", inReady, 1);
    checkOutput("mload_stall_busy", busy, 1);
    applyStimulus(32'hBBBB_BBBB, xc);
    repeat (2) @(negedge clock);
    applyStimulus(32'hFFFF_00CC, xc);
    checkOutput("mload_en", wTmEn, 1);
    checkOutput("mload_data", wTmData, 80'h00CC_BBBB_BBBB_AAAA_AAAA);
    checkOutput("mload_done", done, 1);
    checkOutput("mload_v_en", wVEn, 0);
    @(negedge clock);
    checkOutput("mload_pulses", tmPulses, 1);
    checkOutput("mload_v_pulses", vPulses, 0);
    checkOutput("mload_vec_hold", wVData[2], 64'h2222_2222_1111_1111);

    $display("[TB] out-of-range index 7");
    vPulses = 0; tmPulses = 0; errPulses = 0; donePulses = 0;
    applyStimulus(32'h0000_0007, xc);
    applyStimulus(32'hDEAD_BEEF, xc);
    applyStimulus(32'h1234_5678, xc);
    checkOutput("bad_err", err, 1);
    checkOutput("bad_done", done, 1);
    checkOutput("bad_en", {wVEn, wTmEn}, 0);
    checkOutput("bad_ready", inReady, 0);
    checkOutput("bad_vec_hold", wVData[1], 64'h2222_2222_1111_1111);
    @(negedge clock);
    checkOutput("bad_err_after", err, 0);
    checkOutput("bad_counts", {errPulses[7:0], donePulses[7:0], vPulses[7:0], tmPulses[7:0]}, 32'h0101_0000);
    applyStimulus(32'h0000_0003, xc);
    applyStimulus(32'h3333_3333, xc);
    applyStimulus(32'h4444_4444, xc);
    checkOutput("recover_en", wVEn, 4'b1000);
    checkOutput("recover_data", wVData[3], 64'h4444_4444_3333_3333);
    checkOutput("recover_err", err, 0);
    @(negedge clock);

    $display("[TB] back-to-back vector loads");
    vPulses = 0;
    seq = '{32'h0000_0000, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0000_0001, 32'h0C0C_0C0C, 32'h0D0D_0D0D};
    idx = 0; cyc = 0; readyLow = 0; h0 = 0; h1 = 0;
    inValid = 1'b1;
    while (idx < 6 && cyc < 40) begin
      inData = seq[idx];
      if (inReady) begin
        if (idx == 0) h0 = cycle;
        if (idx == 3) h1 = cycle;
        idx++;
      end else begin
        readyLow++;
      end
      @(negedge clock);
      cyc++;
    end
    inValid = 1'b0;
    checkOutput("b2b_all_sent", idx, 6);
    checkOutput("b2b_spacing", h1 - h0, 4);
    checkOutput("b2b_ready_low", readyLow, 1);
    checkOutput("b2b_en", wVEn, 4'b0010);
    checkOutput("b2b_commit_ready", inReady, 0);
    checkOutput("b2b_data", wVData[1], 64'h0D0D_0D0D_0C0C_0C0C);
    @(negedge clock);
    checkOutput("b2b_pulses", vPulses, 2);

    $display("[TB] reset during a command");
    applyStimulus(32'h0000_0001, xc);
    applyStimulus(32'h5555_5555, xc);
    vPulses = 0; donePulses = 0; errPulses = 0;
    reset = 1'b1;
    #1;
    checkOutput("rst_ready", inReady, 0);
    checkOutput("rst_flags", {busy, done, err, wTmEn, wVEn}, 0);
    checkOutput("rst_vdata", wVData, 0);
    checkOutput("rst_tmdata", wTmData, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_post_ready", inReady, 1);
    checkOutput("rst_post_busy", busy, 0);
    repeat (4) @(negedge clock);
    checkOutput("rst_no_strobe", {vPulses[7:0], donePulses[7:0], errPulses[7:0]}, 0);
    applyStimulus(32'h0000_0001, xc);
    applyStimulus(32'h7777_7777, xc);
    applyStimulus(32'h8888_8888, xc);
    checkOutput("rst_next_en", wVEn, 4'b0010);
    checkOutput("rst_next_data", wVData[1], 64'h8888_8888_7777_7777);
    @(negedge clock);

    $display("[TB] index 8'hFF");
    applyStimulus(32'h0000_00FF, xc);
    applyStimulus(32'h9999_9999, xc);
    applyStimulus(32'hAAAA_0000, xc);
`ifdef REGISTER_LOADER_BROADCAST_EN
    checkOutput("bcast_en", wVEn, 4'b1111);
    checkOutput("bcast_err", err, 0);
    checkOutput("bcast_data", wVData, {4{64'hAAAA_0000_9999_9999}});
`else
    checkOutput("bcast_err", err, 1);
    checkOutput("bcast_en", wVEn, 0);
    checkOutput("bcast_vec_hold", wVData[0], 64'h8888_8888_7777_7777);
`endif
    checkOutput("bcast_done", done, 1);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
